imem_loader: RTL and testbench

- Byte-stream program loader that fills the MIPS instruction memory through its write port, so boot-time program loading does not depend on hierarchical testbench writes.
- Receives a length-prefixed big-endian byte stream over a valid/ready handshake and assembles it into 32-bit words.
- Writes the words to sequential word addresses starting at 0.
- Holds the CPU in reset for the whole load and releases it when the load completes.

---
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: turns a length-prefixed big-endian byte stream into 32-bit
// instruction-memory writes from address 0, holding the CPU in reset until done.
//
// state  | meaning
// IDLE   | post-reset, waiting for start, CPU held in reset
// LEN_HI | waiting for length byte [15:8]
// LEN_LO | waiting for length byte [7:0], length range check
// DATA   | assembling and writing words
// DONE   | load complete, CPU released, reload allowed
// ERR    | length exceeded memory depth, CPU held in reset
module imem_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    state_t                  state, state_nx;
    logic [15:0]             len;
    logic [15:0]             len_new;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [1:0]              byte_cnt;
    logic [23:0]             shift;
    logic                    xfer;
    logic                    start_ok;
    logic                    last_word;
    logic                    word_done;

    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign len_new   = {len[15:8], in_data};
    assign last_word = (16'(word_idx) == len - 16'd1);
    assign word_done = xfer && (state == S_DATA) && (byte_cnt == 2'd3);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LEN_HI;
            S_LEN_HI: if (xfer) state_nx = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_new == 16'd0)
                        state_nx = S_DONE;
                    else if ({1'b0, len_new} > DEPTH)
                        state_nx = S_ERR;
                    else
                        state_nx = S_DATA;
                end
            end
            S_DATA:   if (word_done && last_word) state_nx = S_DONE;
            S_DONE:   if (start) state_nx = S_LEN_HI;
            S_ERR:    if (start) state_nx = S_LEN_HI;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_rst  <= 1'b1;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == S_LEN_HI) || (state_nx == S_LEN_LO) || (state_nx == S_DATA);
            busy     <= (state_nx == S_LEN_HI) || (state_nx == S_LEN_LO) || (state_nx == S_DATA);
            done     <= (state_nx == S_DONE);
            err      <= (state_nx == S_ERR);
            cpu_rst  <= (state_nx != S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                word_idx <= '0;
                byte_cnt <= '0;
            end
            if (xfer) begin
                case (state)
                    S_LEN_HI: len[15:8] <= in_data;
                    S_LEN_LO: len[7:0]  <= in_data;
                    S_DATA: begin
                        shift    <= {shift[15:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx;
                            mem_wdata <= DATA_WIDTH'({shift, in_data});
                            // Holding on the last word keeps the index from wrapping at full depth.
                            if (!last_word)
                                word_idx <= word_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level model pushes expected writes,
// a monitor pops them on every mem_we and checks the one-cycle write latency.
module tb_imem_loader;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        bit            last;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          failures = 0;
    int          n_writes = 0;
    bit          pend_we = 1'b0;

    int          m_phase = 3;   // 0 len_hi, 1 len_lo, 2 data, 3 idle/done/err
    logic [15:0] m_len = '0;
    int          m_word = 0;
    int          m_byte = 0;
    logic [31:0] m_shift = '0;

    bit          mon_exp;
    wr_t         mon_e;

    always @(posedge clk) begin
        mon_exp = pend_we;
        pend_we = 1'b0;
        #1;
        checks++;
        if (mem_we !== mon_exp) begin
            failures++;
            $display("FAIL we_timing got=%0b exp=%0b t=%0t", mem_we, mon_exp, $time);
        end
        if (mem_we === 1'b1) begin
            n_writes++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h t=%0t", mem_addr, mem_wdata, $time);
            end else begin
                mon_e = sb.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    failures++;
                    $display("FAIL write got=%0d:%h exp=%0d:%h", mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
                if (mon_e.last) begin
                    checks++;
                    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
                        failures++;
                        $display("FAIL last_write_done got done=%0b cpu_rst=%0b exp done=1 cpu_rst=0", done, cpu_rst);
                    end
                end
            end
        end
    end

    task automatic model_clear();
        m_phase = 3;
        m_len   = '0;
        m_word  = 0;
        m_byte  = 0;
        m_shift = '0;
        pend_we = 1'b0;
        sb.delete();
    endtask

    task automatic model_accept(input logic [7:0] b);
        case (m_phase)
            0: begin m_len[15:8] = b; m_phase = 1; end
            1: begin
                m_len[7:0] = b;
                if (m_len == 16'd0 || m_len > 16'd512) m_phase = 3;
                else begin m_phase = 2; m_word = 0; m_byte = 0; end
            end
            2: begin
                m_shift = {m_shift[23:0], b};
                m_byte++;
                if (m_byte == 4) begin
                    m_byte = 0;
                    sb.push_back('{AW'(m_word), m_shift, (m_word + 1 == int'(m_len))});
                    pend_we = 1'b1;
                    m_word++;
                    if (m_word == int'(m_len)) m_phase = 3;
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        if (m_phase == 3) begin m_phase = 0; m_word = 0; m_byte = 0; end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_bytes(input logic [7:0] bytes[$], input bit throttle, input int start_at);
        int i = 0;
        int guard = 0;
        bit ph = 1'b0;
        while (i < bytes.size() && guard < 10000) begin
            @(negedge clk);
            start    = (guard == start_at);
            ph       = ~ph;
            in_valid = throttle ? ph : 1'b1;
            in_data  = in_valid ? bytes[i] : 8'hEE;
            if (in_valid && in_ready) begin
                model_accept(bytes[i]);
                i++;
            end
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0; in_data = 8'h00;
        checks++;
        if (i != bytes.size()) begin
            failures++;
            $display("FAIL stream_timeout got=%0d bytes exp=%0d", i, bytes.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, mem_we, busy, done, err, cpu_rst} !== 6'b000001 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_values got rdy=%0b we=%0b busy=%0b done=%0b err=%0b cpu_rst=%0b addr=%0d data=%h exp 0,0,0,0,0,1,0,0",
                     in_ready, mem_we, busy, done, err, cpu_rst, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_basic(input bit throttle);
        logic [7:0] s[$] = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h08, 8'h20, 8'h24, 8'h02, 8'h00, 8'h09};
        int n0;
        do_reset();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got busy=%0b rdy=%0b cpu_rst=%0b exp 1,1,1", busy, in_ready, cpu_rst);
        end
        n0 = n_writes;
        drive_bytes(s, throttle, -1);
        checks++;
        if (n_writes - n0 != 3 || done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL basic_end thr=%0b got writes=%0d done=%0b cpu_rst=%0b busy=%0b rdy=%0b left=%0d exp 3,1,0,0,0,0",
                     throttle, n_writes - n0, done, cpu_rst, busy, in_ready, sb.size());
        end
    endtask

    task automatic test_len0();
        logic [7:0] s[$] = '{8'h00, 8'h00};
        int n0;
        pulse_start();
        n0 = n_writes;
        drive_bytes(s, 1'b0, -1);
        checks++;
        if (n_writes != n0 || done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL len0 got writes=%0d done=%0b cpu_rst=%0b err=%0b exp 0,1,0,0", n_writes - n0, done, cpu_rst, err);
        end
    endtask

    task automatic test_len512();
        logic [7:0] s[$];
        logic [31:0] w;
        int n0;
        s.push_back(8'h02);
        s.push_back(8'h00);
        for (int k = 0; k < 512; k++) begin
            w = $urandom;
            s.push_back(w[31:24]); s.push_back(w[23:16]); s.push_back(w[15:8]); s.push_back(w[7:0]);
        end
        pulse_start();
        n0 = n_writes;
        drive_bytes(s, 1'b0, -1);
        checks++;
        if (n_writes - n0 != 512 || mem_addr !== 9'd511 || done !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL len512 got writes=%0d addr=%0d done=%0b exp 512,511,1", n_writes - n0, mem_addr, done);
        end
    endtask

    task automatic test_len_over();
        logic [7:0] s[$] = '{8'h02, 8'h01};
        int n0;
        pulse_start();
        n0 = n_writes;
        drive_bytes(s, 1'b0, -1);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || n_writes != n0) begin
            failures++;
            $display("FAIL len_over got err=%0b cpu_rst=%0b done=%0b busy=%0b rdy=%0b writes=%0d exp 1,1,0,0,0,0",
                     err, cpu_rst, done, busy, in_ready, n_writes - n0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s1[$] = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
                              8'h05, 8'h06, 8'h07, 8'h08, 8'hDE, 8'hAD};
        logic [7:0] s2[$] = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        int n0;
        do_reset();
        pulse_start();
        n0 = n_writes;
        drive_bytes(s1, 1'b0, -1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if ({in_ready, mem_we, busy, done, err, cpu_rst} !== 6'b000001 || mem_addr !== '0 || mem_wdata !== '0 || n_writes - n0 != 2) begin
            failures++;
            $display("FAIL reset_mid got rdy=%0b we=%0b busy=%0b done=%0b err=%0b cpu_rst=%0b addr=%0d data=%h writes=%0d exp 0,0,0,0,0,1,0,0,2",
                     in_ready, mem_we, busy, done, err, cpu_rst, mem_addr, mem_wdata, n_writes - n0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        pulse_start();
        n0 = n_writes;
        drive_bytes(s2, 1'b0, -1);
        checks++;
        if (n_writes - n0 != 1 || done !== 1'b1 || mem_wdata !== 32'h11223344) begin
            failures++;
            $display("FAIL reset_mid_reload got writes=%0d done=%0b data=%h exp 1,1,11223344", n_writes - n0, done, mem_wdata);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] s[$] = '{8'h00, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                             8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
        logic [7:0] s2[$] = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        int n0;
        do_reset();
        pulse_start();
        n0 = n_writes;
        drive_bytes(s, 1'b0, 7);
        checks++;
        if (n_writes - n0 != 3 || done !== 1'b1 || mem_addr !== 9'd2) begin
            failures++;
            $display("FAIL start_busy got writes=%0d done=%0b addr=%0d exp 3,1,2", n_writes - n0, done, mem_addr);
        end
        @(negedge clk);
        start = 1'b1;
        m_phase = 0; m_word = 0; m_byte = 0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cpu_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reload_start got cpu_rst=%0b done=%0b busy=%0b exp 1,0,1", cpu_rst, done, busy);
        end
        n0 = n_writes;
        drive_bytes(s2, 1'b0, -1);
        checks++;
        if (n_writes - n0 != 1 || mem_addr !== 9'd0 || mem_wdata !== 32'hCAFEF00D || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL reload got writes=%0d addr=%0d data=%h cpu_rst=%0b exp 1,0,cafef00d,0",
                     n_writes - n0, mem_addr, mem_wdata, cpu_rst);
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_len0();
        test_len512();
        test_len_over();
        test_reset_mid();
        test_start_ignored();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
